// File: rtl/polaris_pkg.sv
// polaris_pkg: shared data-bus size encodings, bridge state enum and beat helpers
package polaris_pkg;
  localparam logic [1:0] DSIZ_BYTE  = 2'b00;
  localparam logic [1:0] DSIZ_HALF  = 2'b01;
  localparam logic [1:0] DSIZ_WORD  = 2'b10;
  localparam logic [1:0] DSIZ_DWORD = 2'b11;
  typedef enum logic [1:0] {ST_IDLE, ST_BUS, ST_DONE} bridge_state_e;
  function automatic logic [1:0] last_beat(input logic [1:0] siz);
    return siz == DSIZ_DWORD ? 2'd3 : siz == DSIZ_WORD ? 2'd2 - 2'd1 : 2'd0;
  endfunction
  function automatic logic [63:0] align_adr(input logic [63:0] adr, input logic [1:0] siz);
    return siz == DSIZ_DWORD ? {adr[63:3], 3'b0} :
           siz == DSIZ_WORD  ? {adr[63:2], 2'b0} : {adr[63:1], 1'b0};
  endfunction
endpackage

// File: rtl/dbus_bridge_if.sv
// dbus_bridge_if: CPU data-bus and 16-bit external-bus signals of the bridge
interface dbus_bridge_if;
  logic        dcyc_i;
  logic        dstb_i;
  logic        dwe_i;
  logic [1:0]  dsiz_i;
  logic        dsigned_i;
  logic [63:0] dadr_i;
  logic [63:0] ddat_i;
  logic        dack_o;
  logic [63:0] ddat_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [63:0] wb_adr_o;
  logic [1:0]  wb_sel_o;
  logic [15:0] wb_dat_o;
  logic [15:0] wb_dat_i;
  logic        wb_ack_i;
  modport master (
    output dcyc_i, dstb_i, dwe_i, dsiz_i, dsigned_i, dadr_i, ddat_i, wb_dat_i, wb_ack_i,
    input  dack_o, ddat_o, wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o
  );
  modport slave (
    input  dcyc_i, dstb_i, dwe_i, dsiz_i, dsigned_i, dadr_i, ddat_i, wb_dat_i, wb_ack_i,
    output dack_o, ddat_o, wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o
  );
endinterface

// File: rtl/dbus_extend.sv
// dbus_extend: picks the byte lane and sign/zero-extends an assembled load to 64 bits
module dbus_extend
  import polaris_pkg::*;
(
  input  logic [63:0] raw_i,
  input  logic [1:0]  siz_i,
  input  logic        signed_i,
  input  logic        lane_i,
  output logic [63:0] ext_o
);
  logic [7:0] b;
  // lane selection then extension from bit 7/15/31; dword passes through
  always_comb begin
    b = lane_i ? raw_i[15:8] : raw_i[7:0];
    ext_o = siz_i == DSIZ_BYTE ? {{56{signed_i & b[7]}}, b} :
            siz_i == DSIZ_HALF ? {{48{signed_i & raw_i[15]}}, raw_i[15:0]} :
            siz_i == DSIZ_WORD ? {{32{signed_i & raw_i[31]}}, raw_i[31:0]} : raw_i;
  end
endmodule

// File: rtl/dbus_bridge.sv
// dbus_bridge: splits 64-bit CPU loads/stores into naturally aligned 16-bit external beats
module dbus_bridge
  import polaris_pkg::*;
(
  input  logic         clk_i,
  input  logic         reset_i,
  dbus_bridge_if.slave bus
);
  bridge_state_e state_q, state_d;
  logic [63:0] dat_q, dat_d, rdat_q, rdat_d, ddat_q, ddat_d, wb_adr_q, wb_adr_d;
  logic [1:0]  siz_q, siz_d, beat_q, beat_d, sel_q, sel_d;
  logic        sgn_q, sgn_d, we_q, we_d;
  logic [63:0] asm_data, ext;
  logic        ack;
  assign ack = state_q == ST_BUS && bus.wb_ack_i;
  assign asm_data = (rdat_q & ~(64'hFFFF << {beat_q, 4'b0})) | ({48'b0, bus.wb_dat_i} << {beat_q, 4'b0});
  dbus_extend u_ext (
    .raw_i   (asm_data),
    .siz_i   (siz_q),
    .signed_i(sgn_q),
    .lane_i  (sel_q[1]),
    .ext_o   (ext)
  );
  // state and latched-request registers, cleared asynchronously
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q  <= ST_IDLE;
      dat_q    <= '0;
      rdat_q   <= '0;
      ddat_q   <= '0;
      wb_adr_q <= '0;
      siz_q    <= '0;
      beat_q   <= '0;
      sel_q    <= '0;
      sgn_q    <= 1'b0;
      we_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      dat_q    <= dat_d;
      rdat_q   <= rdat_d;
      ddat_q   <= ddat_d;
      wb_adr_q <= wb_adr_d;
      siz_q    <= siz_d;
      beat_q   <= beat_d;
      sel_q    <= sel_d;
      sgn_q    <= sgn_d;
      we_q     <= we_d;
    end
  end
  // accept a request in IDLE, step beats on each ack in BUS, pulse DONE once
  always_comb begin
    state_d  = state_q;
    dat_d    = dat_q;
    rdat_d   = rdat_q;
    ddat_d   = ddat_q;
    wb_adr_d = wb_adr_q;
    siz_d    = siz_q;
    beat_d   = beat_q;
    sel_d    = sel_q;
    sgn_d    = sgn_q;
    we_d     = we_q;
    case (state_q)
      ST_IDLE: if (bus.dcyc_i && bus.dstb_i) begin
        state_d  = ST_BUS;
        dat_d    = bus.ddat_i;
        rdat_d   = '0;
        wb_adr_d = align_adr(bus.dadr_i, bus.dsiz_i);
        siz_d    = bus.dsiz_i;
        beat_d   = '0;
        sel_d    = bus.dsiz_i != DSIZ_BYTE ? 2'b11 : bus.dadr_i[0] ? 2'b10 : 2'b01;
        sgn_d    = bus.dsigned_i;
        we_d     = bus.dwe_i;
      end
      ST_BUS: if (ack) begin
        rdat_d = asm_data;
        if (beat_q == last_beat(siz_q)) begin
          state_d = ST_DONE;
          ddat_d  = we_q ? ddat_q : ext;
        end else begin
          beat_d   = beat_q + 2'd1;
          wb_adr_d = wb_adr_q + 64'd2;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end
  assign bus.dack_o   = state_q == ST_DONE;
  assign bus.ddat_o   = ddat_q;
  assign bus.wb_cyc_o = state_q == ST_BUS;
  assign bus.wb_stb_o = state_q == ST_BUS;
  assign bus.wb_we_o  = we_q && state_q == ST_BUS;
  assign bus.wb_adr_o = wb_adr_q;
  assign bus.wb_sel_o = sel_q;
  assign bus.wb_dat_o = siz_q == DSIZ_BYTE ? {2{dat_q[7:0]}} : dat_q[{beat_q, 4'b0} +: 16];
endmodule
